// File: rtl/demux2_stream.sv
// 1-to-2 registered stream demultiplexer with manual or round-robin routing.
// Each output port has a one-entry register and a free-running delivered-beat counter.
module demux2_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sel,
  output logic              in_ready,
  input  logic              rr_mode,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_valid,
  input  logic              out2_ready,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2
);

  logic rr_ptr;
  logic tgt_c;
  logic free1_c;
  logic free2_c;
  logic xfer_c;
  logic load1_c;
  logic load2_c;

  // Route and acceptance: a slot is free when empty or draining this cycle.
  always_comb begin
    tgt_c   = rr_mode ? rr_ptr : in_sel;
    free1_c = !out1_valid || out1_ready;
    free2_c = !out2_valid || out2_ready;
    xfer_c  = in_valid && (tgt_c ? free2_c : free1_c);
    load1_c = xfer_c && !tgt_c;
    load2_c = xfer_c && tgt_c;
  end

  assign in_ready = tgt_c ? free2_c : free1_c;

  // Port 1 register: refill wins over drain; data holds after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_data  <= '0;
      out1_valid <= 1'b0;
    end else if (load1_c) begin
      out1_data  <= in_data;
      out1_valid <= 1'b1;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

  // Port 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2_data  <= '0;
      out2_valid <= 1'b0;
    end else if (load2_c) begin
      out2_data  <= in_data;
      out2_valid <= 1'b1;
    end else if (out2_ready) begin
      out2_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances only on round-robin transfers; mode switches keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (xfer_c && rr_mode) begin
      rr_ptr <= !rr_ptr;
    end
  end

  // Delivered-beat counters, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (out1_valid && out1_ready) cnt1 <= cnt1 + CNT_W'(1);
      if (out2_valid && out2_ready) cnt2 <= cnt2 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux2_stream.sv
// Directed self-checking bench for demux2_stream (CNT_W=4 to exercise counter wrap).
module tb_demux2_stream;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_sel;
  logic              in_ready;
  logic              rr_mode;
  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out2_data;
  logic              out2_valid;
  logic              out2_ready;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  cnt2;

  int n_checks;
  int n_pass;

  demux2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .rr_mode(rr_mode),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] q2[$];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    rr_mode = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    drive(1'b0, '0, 1'b0);

    // Reset state
    do_reset();
    check("rst_out1_valid", 32'(out1_valid), 0);
    check("rst_out2_valid", 32'(out2_valid), 0);
    check("rst_out1_data", 32'(out1_data), 0);
    check("rst_out2_data", 32'(out2_data), 0);
    check("rst_cnt1", 32'(cnt1), 0);
    check("rst_cnt2", 32'(cnt2), 0);

    // Manual routing A1->1, B2->2, C3->1 back-to-back
    drive(1'b1, 8'hA1, 1'b0); #1;
    check("man_rdy0", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'hB2, 1'b1); #1;
    check("man_o1_v", 32'(out1_valid), 1);
    check("man_o1_a1", 32'(out1_data), 32'hA1);
    check("man_rdy1", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'hC3, 1'b0); #1;
    check("man_o2_b2", 32'(out2_data), 32'hB2);
    check("man_o2_v", 32'(out2_valid), 1);
    check("man_o1_idle", 32'(out1_valid), 0);
    check("man_rdy2", 32'(in_ready), 1);
    tick();
    drive(1'b0, '0, 1'b0); #1;
    check("man_o1_c3", 32'(out1_data), 32'hC3);
    check("man_o1_v3", 32'(out1_valid), 1);
    tick();
    check("man_cnt1", 32'(cnt1), 2);
    check("man_cnt2", 32'(cnt2), 1);

    // Backpressure on port 1
    out1_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0); #1;
    check("bp_rdy_empty", 32'(in_ready), 1);
    tick();
    drive(1'b1, 8'h22, 1'b0); #1;
    check("bp_rdy_full", 32'(in_ready), 0);
    check("bp_hold_11", 32'(out1_data), 32'h11);
    tick();
    #1;
    check("bp_still_held", 32'(out1_data), 32'h11);
    check("bp_still_stall", 32'(in_ready), 0);
    out1_ready = 1'b1; #1;
    check("bp_rdy_drain", 32'(in_ready), 1);
    tick();
    drive(1'b0, '0, 1'b0);
    out1_ready = 1'b0; #1;
    check("bp_o1_22", 32'(out1_data), 32'h22);
    check("bp_o1_v", 32'(out1_valid), 1);
    check("bp_cnt1", 32'(cnt1), 3);

    // Independent port 2 while port 1 stalls
    drive(1'b1, 8'h55, 1'b1); #1;
    check("ind_rdy", 32'(in_ready), 1);
    tick();
    drive(1'b0, '0, 1'b0); #1;
    check("ind_o2_55", 32'(out2_data), 32'h55);
    check("ind_o2_v", 32'(out2_valid), 1);
    check("ind_o1_held", 32'(out1_data), 32'h22);
    check("ind_o1_v", 32'(out1_valid), 1);
    out1_ready = 1'b1;
    tick();
    #1;
    check("ind_cnt1", 32'(cnt1), 4);
    check("ind_cnt2", 32'(cnt2), 2);

    // Round-robin with out2 blocked in cycles 3..5
    do_reset();
    rr_mode = 1'b1;
    begin
      int idx;
      logic acc;
      idx = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        out1_ready = 1'b1;
        out2_ready = !(cyc >= 3 && cyc <= 5);
        if (idx < 6) drive(1'b1, DATA_W'(idx + 1), 1'b0);
        else drive(1'b0, '0, 1'b0);
        #1;
        if (out1_valid && out1_ready) q1.push_back(out1_data);
        if (out2_valid && out2_ready) q2.push_back(out2_data);
        if (cyc == 5) check("rr_stall", 32'(in_ready), 0);
        acc = in_valid && in_ready;
        tick();
        if (acc) idx++;
      end
    end
    check("rr_q1_n", 32'(q1.size()), 3);
    check("rr_q2_n", 32'(q2.size()), 3);
    if (q1.size() == 3 && q2.size() == 3) begin
      check("rr_q1_0", 32'(q1[0]), 1);
      check("rr_q1_1", 32'(q1[1]), 3);
      check("rr_q1_2", 32'(q1[2]), 5);
      check("rr_q2_0", 32'(q2[0]), 2);
      check("rr_q2_1", 32'(q2[1]), 4);
      check("rr_q2_2", 32'(q2[2]), 6);
    end

    // Counter wrap on port 2
    do_reset();
    rr_mode = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      tick();
      if (i == 15) check("wrap_15", 32'(cnt2), 15);
      if (i == 16) check("wrap_16", 32'(cnt2), 0);
      if (i == 17) check("wrap_17", 32'(cnt2), 1);
    end
    check("wrap_cnt1", 32'(cnt1), 0);

    // Mid-operation asynchronous reset with both ports full and stalled
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b0);
    tick();
    drive(1'b1, 8'hBB, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0); #1;
    check("mr_pre_o1", 32'(out1_data), 32'hAA);
    check("mr_pre_o2", 32'(out2_data), 32'hBB);
    #1 rst_n = 1'b0;
    #1;
    check("mr_o1_v", 32'(out1_valid), 0);
    check("mr_o2_v", 32'(out2_valid), 0);
    check("mr_o1_d", 32'(out1_data), 0);
    check("mr_o2_d", 32'(out2_data), 0);
    check("mr_cnt2", 32'(cnt2), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rr_mode = 1'b1;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    tick();
    check("mr_post_o1_v", 32'(out1_valid), 0);
    drive(1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0); #1;
    check("mr_rr_o1", 32'(out1_data), 32'h77);
    check("mr_rr_o1_v", 32'(out1_valid), 1);
    check("mr_rr_o2_v", 32'(out2_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
